// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, multi-cycle M-op freeze, taken-branch flush.
// Latency: all enables/flushes are combinational from state, cnt and inputs; state changes next edge.
// Backpressure: drops if_en/id_en (and exe_en for M-ops) for LOAD_LAT / DIV_LAT cycles per event.
module pipe_hazard_ctrl #(
    parameter int LOAD_LAT = 1,
    parameter int DIV_LAT  = 32,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      id_inst,
    input  logic             exe_is_load,
    input  logic [4:0]       exe_rd,
    input  logic             exe_div_start,
    input  logic             exe_branch_taken,
    output logic             if_en,
    output logic             id_en,
    output logic             exe_en,
    output logic             id_flush,
    output logic             exe_flush,
    output logic             mem_flush,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cycles
);

    // Down-counter must hold the larger of the two reload values.
    localparam int MAX_LAT = (DIV_LAT > LOAD_LAT) ? DIV_LAT : LOAD_LAT;
    localparam int CW      = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

    localparam logic [CW-1:0] LOAD_RELOAD = CW'(LOAD_LAT - 1);
    localparam logic [CW-1:0] DIV_RELOAD  = CW'(DIV_LAT - 1);

    localparam logic [6:0] OP_LUI   = 7'h37;
    localparam logic [6:0] OP_AUIPC = 7'h17;
    localparam logic [6:0] OP_JAL   = 7'h6F;
    localparam logic [6:0] OP_REG   = 7'h33;
    localparam logic [6:0] OP_STORE = 7'h23;
    localparam logic [6:0] OP_BR    = 7'h63;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_DIV_BUSY   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic [6:0] opcode;
    logic [4:0] rs1, rs2;
    logic       rs1_used, rs2_used;
    logic       load_hazard;

    // Immediate/funct fields play no part in hazard detection.
    logic unused_inst_bits;
    assign unused_inst_bits = ^{id_inst[31:25], id_inst[14:7]};

    // Decode which source registers the ID instruction actually reads and compare against EXE load rd.
    always_comb begin
        opcode      = id_inst[6:0];
        rs1         = id_inst[19:15];
        rs2         = id_inst[24:20];
        rs1_used    = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
        rs2_used    = (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BR);
        load_hazard = exe_is_load && (exe_rd != 5'd0) &&
                      ((rs1_used && (rs1 == exe_rd)) || (rs2_used && (rs2 == exe_rd)));
    end

    // Next-state, counter reload and pipeline control outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        if_en     = 1'b1;
        id_en     = 1'b1;
        exe_en    = 1'b1;
        id_flush  = 1'b0;
        exe_flush = 1'b0;
        mem_flush = 1'b0;
        busy      = 1'b0;
        if (!rst) begin
            unique case (state_q)
                ST_RUN: begin
                    if (exe_branch_taken) begin
                        // Wrong-path instructions in IF/ID and ID/EXE are squashed; any hazard is moot.
                        id_flush  = 1'b1;
                        exe_flush = 1'b1;
                    end else if (exe_div_start) begin
                        if_en     = 1'b0;
                        id_en     = 1'b0;
                        exe_en    = 1'b0;
                        mem_flush = 1'b1;
                        if (DIV_LAT > 1) begin
                            cnt_d   = DIV_RELOAD;
                            state_d = ST_DIV_BUSY;
                        end
                    end else if (load_hazard) begin
                        if_en     = 1'b0;
                        id_en     = 1'b0;
                        exe_flush = 1'b1;
                        if (LOAD_LAT > 1) begin
                            cnt_d   = LOAD_RELOAD;
                            state_d = ST_LOAD_STALL;
                        end
                    end
                end
                ST_LOAD_STALL: begin
                    if_en     = 1'b0;
                    id_en     = 1'b0;
                    exe_flush = 1'b1;
                    busy      = 1'b1;
                    cnt_d     = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) state_d = ST_RUN;
                end
                ST_DIV_BUSY: begin
                    if_en     = 1'b0;
                    id_en     = 1'b0;
                    exe_en    = 1'b0;
                    mem_flush = 1'b1;
                    busy      = 1'b1;
                    cnt_d     = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) state_d = ST_RUN;
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // Saturating count of cycles where fetch is held.
    always_comb begin
        stall_d = stall_q;
        if (!if_en && (stall_q != {CNT_W{1'b1}})) stall_d = stall_q + 1'b1;
    end

    assign stall_cycles = stall_q;

    // State, counter and perf counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
        end
    end

endmodule
